// File: rtl/rs232_pkg.sv
// Shared UART definitions: default line settings, derived bit timing and FSM encoding.
package rs232_pkg;

  localparam int DEF_CLK_FREQ    = 50_000_000;
  localparam int DEF_BAUD        = 9600;
  localparam int DEF_BIT_CNT_MAX = DEF_CLK_FREQ / DEF_BAUD;
  localparam int DEF_HALF_CNT    = DEF_BIT_CNT_MAX / 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Baud counter width; it must hold BIT_CNT_MAX-1.
  function automatic int cnt_width(input int bit_cnt_max);
    return (bit_cnt_max > 2) ? $clog2(bit_cnt_max) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value selectable per bit.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff_p0;
  logic [WIDTH-1:0] ff_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_p0 <= RST_VAL;
      ff_p1 <= RST_VAL;
    end else begin
      ff_p0 <= d;
      ff_p1 <= ff_p0;
    end
  end

  assign q = ff_p1;

endmodule

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, byte strobe or framing-error strobe.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BIT_CNT_MAX = CLK_FREQ / BAUD;
  localparam int HALF_CNT    = BIT_CNT_MAX / 2;
  localparam int CNT_W       = cnt_width(BIT_CNT_MAX);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  logic [0:0]       rx_sync;
  logic             rx_p1;
  logic             rx_p2;
  logic             fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Stages p0/p1: metastability filter
  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(sys_clk),
    .rst(sys_rst),
    .d  (rx),
    .q  (rx_sync)
  );

  assign rx_p1 = rx_sync[0];

  // Stage p2: previous synchronized value for edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rx_p2 <= 1'b1;
    else         rx_p2 <= rx_p1;
  end

  assign fall    = rx_p2 & ~rx_p1;
  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_out  <= '0;
      data_flag <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      data_flag <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fall) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A start bit that is already high again at its midpoint was a glitch.
            state   <= rx_p1 ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_p1, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            // Leave at mid-stop so a start bit right at the stop-bit end is caught.
            state <= ST_IDLE;
            if (rx_p1) begin
              data_out  <= shift;
              data_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/rs232_rx.md
RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001: Parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002: Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003: sys_clk  input  1  sole clock; all state changes on rising edge.
REQ-004: sys_rst  input  1  reset, asynchronous, active-high.
REQ-005: rx  input  1  asynchronous serial line; idles high; 8N1 frames, LSB first.
REQ-006: data_out  output  8  last correctly received byte.
REQ-007: data_flag  output  1  one-cycle strobe: data_out is newly valid.
REQ-008: frame_err  output  1  one-cycle strobe: stop bit sampled low.
REQ-009: rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010: rx SHALL pass through a 2-flop synchronizer, then a third flop; start detect = third flop high AND second flop low (falling edge).
REQ-011: BIT_CNT_MAX SHALL equal CLK_FREQ/BAUD (integer divide; 5208 at defaults); HALF_CNT SHALL equal BIT_CNT_MAX/2 (2604).
REQ-012: FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013: IDLE -> START on detected falling edge; the baud counter clears to 0 on that cycle.
REQ-014: In START, the synchronized rx SHALL be sampled when the counter reaches HALF_CNT-1; if high (glitch), the FSM returns to IDLE with no strobe; if low, the counter clears and the FSM enters DATA.
REQ-015: From the start-bit midpoint onward, every sample SHALL occur at counter = BIT_CNT_MAX-1, after which the counter clears (mid-bit sampling).
REQ-016: In DATA, 8 samples SHALL be shifted into a shift register LSB first; a 3-bit bit index counts 0..7; after bit 7 the FSM enters STOP.
REQ-017: In STOP, one sample is taken; if high, data_out loads the shift register and data_flag pulses high for exactly one cycle on the next clock.
REQ-018: If the stop sample is low, frame_err pulses for one cycle, data_out SHALL hold its previous value, and data_flag SHALL stay low.
REQ-019: After the stop sample (either outcome), the FSM SHALL return to IDLE immediately, so a start bit beginning at the nominal end of the stop bit is accepted (back-to-back frames).
REQ-020: A low-held line (break) after a frame error SHALL NOT retrigger; a new frame requires a high-to-low transition.
REQ-021: data_flag and frame_err SHALL never be high in the same cycle.
REQ-022: Latency from the first sys_clk edge seeing rx low to data_flag high SHALL be 2 + HALF_CNT + 9*BIT_CNT_MAX + 1 cycles ±1.
REQ-023: Falling edges on rx outside IDLE SHALL be ignored.

Reset
REQ-024: While sys_rst is high: FSM = IDLE, counters = 0, shift register = 0, data_out = 0, data_flag = 0, frame_err = 0, rx_busy = 0, synchronizer flops = 1 (line-idle value).
REQ-025: Reset asserted mid-frame SHALL abort the frame with no strobe; the next full frame after release SHALL be received correctly.

Structure
REQ-026: A shared package rs232_pkg SHALL hold the FSM state encoding and the defaults CLK_FREQ and BAUD, with BIT_CNT_MAX and HALF_CNT derived from them; rs232_tx shares that package.
REQ-027: One sub-module, sync_2ff (parameterized width, reset value 1), SHALL implement the synchronizer; everything else stays in rs232_rx.

Verification (defaults: 20 ns clock, 1 bit = 5208 clocks)
REQ-028: Frame 0x0F at nominal baud -> data_out = 0x0F, data_flag high one cycle, frame_err never high.
REQ-029: 0x55 immediately followed by 0xAA (1 stop bit each) -> two data_flag pulses, data_out 0x55 then 0xAA.
REQ-030: rx low for 1000 clocks, then high -> no strobe, rx_busy drops back to 0 at the START sample.
REQ-031: After a good 0x3C, send 0xA5 with stop bit low -> frame_err pulse, data_out stays 0x3C, no data_flag.
REQ-032: sys_rst pulsed during data bit 3 of a frame -> all outputs 0 and FSM in IDLE; next frame 0xC3 -> data_out = 0xC3.
REQ-033: Loopback rs232_tx.tx -> rs232_rx.rx, rs232_tx data_in = 0x0F with data_flag pulsed -> rs232_rx data_out = 0x0F.
